fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Multithreaded instruction fetch: round-robin PC issue, in-order response tagging,
// and a killable output buffer feeding decode.
module fetch_stage #(
    parameter int unsigned  NUM_THREADS = 4,
    parameter logic [31:0]  RESET_PC    = 32'h0000_0000,
    parameter int unsigned  DEPTH       = 4,
    localparam int unsigned TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [TW-1:0] redirect_tid_i,
    input  logic [31:0]   redirect_pc_i,
    output logic          imem_req_o,
    output logic [31:0]   imem_addr_o,
    input  logic          imem_ready_i,
    input  logic          imem_valid_i,
    input  logic [31:0]   imem_data_i,
    output logic          instr_valid_o,
    output logic [31:0]   instr_o,
    output logic [31:0]   pc_o,
    output logic [TW-1:0] thread_id_o
);
    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [TW-1:0] LAST_TID = TW'(NUM_THREADS - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]      r_pc [NUM_THREADS];
    logic [TW-1:0]    r_rr;

    // Tags of requests accepted by memory but not yet answered
    logic [31:0]      r_pend_pc  [DEPTH];
    logic [TW-1:0]    r_pend_tid [DEPTH];
    logic [DEPTH-1:0] r_pend_kill;
    logic [AW-1:0]    r_pend_rd, r_pend_wr;
    logic [CW-1:0]    r_pend_cnt;

    // Answered instructions waiting for decode
    logic [31:0]      r_buf_data [DEPTH];
    logic [31:0]      r_buf_pc   [DEPTH];
    logic [TW-1:0]    r_buf_tid  [DEPTH];
    logic [DEPTH-1:0] r_buf_kill;
    logic [AW-1:0]    r_buf_rd, r_buf_wr;
    logic [CW-1:0]    r_buf_cnt;

    logic [CW-1:0]    w_count;
    logic             w_redir_rr, w_accept, w_resp, w_resp_kill;
    logic             w_head_vld, w_head_kill, w_pop;

    function automatic logic [AW-1:0] idx_inc(input logic [AW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + AW'(1);
    endfunction

    always_comb begin
        w_count       = r_pend_cnt + r_buf_cnt;
        w_redir_rr    = redirect_i && (redirect_tid_i == r_rr);
        imem_req_o    = !rst && (w_count < FULL_CNT) && !w_redir_rr;
        imem_addr_o   = r_pc[r_rr];
        w_accept      = imem_req_o && imem_ready_i;
        w_resp        = !rst && imem_valid_i && (r_pend_cnt != '0);
        // A redirect landing on the same edge as the response must still kill it
        w_resp_kill   = r_pend_kill[r_pend_rd] ||
                        (redirect_i && (redirect_tid_i == r_pend_tid[r_pend_rd]));
        w_head_vld    = (r_buf_cnt != '0);
        w_head_kill   = r_buf_kill[r_buf_rd];
        w_pop         = w_head_vld && (w_head_kill || !stall_i);
        instr_valid_o = !rst && w_head_vld && !w_head_kill;
        instr_o       = instr_valid_o ? r_buf_data[r_buf_rd] : '0;
        pc_o          = instr_valid_o ? r_buf_pc[r_buf_rd]   : '0;
        thread_id_o   = instr_valid_o ? r_buf_tid[r_buf_rd]  : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_THREADS; i++) r_pc[i] <= RESET_PC;
            r_rr        <= '0;
            r_pend_rd   <= '0;
            r_pend_wr   <= '0;
            r_pend_cnt  <= '0;
            r_pend_kill <= '0;
            r_buf_rd    <= '0;
            r_buf_wr    <= '0;
            r_buf_cnt   <= '0;
            r_buf_kill  <= '0;
        end else begin
            if (w_accept) begin
                r_pc[r_rr] <= r_pc[r_rr] + 32'd4;
                r_rr       <= (r_rr == LAST_TID) ? '0 : r_rr + TW'(1);
                r_pend_wr  <= idx_inc(r_pend_wr);
            end
            if (redirect_i && (32'(redirect_tid_i) < NUM_THREADS))
                r_pc[redirect_tid_i] <= redirect_pc_i;
            if (w_resp) begin
                r_pend_rd <= idx_inc(r_pend_rd);
                r_buf_wr  <= idx_inc(r_buf_wr);
            end
            if (w_pop) r_buf_rd <= idx_inc(r_buf_rd);
            r_pend_cnt <= r_pend_cnt + CW'(w_accept) - CW'(w_resp);
            r_buf_cnt  <= r_buf_cnt + CW'(w_resp) - CW'(w_pop);
            for (int i = 0; i < DEPTH; i++) begin
                if (redirect_i && (r_pend_tid[i] == redirect_tid_i)) r_pend_kill[i] <= 1'b1;
                if (redirect_i && (r_buf_tid[i] == redirect_tid_i))  r_buf_kill[i]  <= 1'b1;
            end
            if (w_accept) r_pend_kill[r_pend_wr] <= 1'b0;
            if (w_resp)   r_buf_kill[r_buf_wr]   <= w_resp_kill;
        end
    end

    // Payload storage; occupancy is tracked by the pointers above
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pend_pc[r_pend_wr]  <= r_pc[r_rr];
            r_pend_tid[r_pend_wr] <= r_rr;
        end
        if (w_resp) begin
            r_buf_data[r_buf_wr] <= imem_data_i;
            r_buf_pc[r_buf_wr]   <= r_pend_pc[r_pend_rd];
            r_buf_tid[r_buf_wr]  <= r_pend_tid[r_pend_rd];
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every cycle, plus
// directed scenarios with hand-derived literal expectations.
module tb_fetch_stage;
    localparam int unsigned NT  = 4;
    localparam int unsigned DEP = 4;
    localparam int unsigned TW  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_i;
    logic          redirect_i;
    logic [TW-1:0] redirect_tid_i;
    logic [31:0]   redirect_pc_i;
    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          imem_ready_i;
    logic          imem_valid_i;
    logic [31:0]   imem_data_i;
    logic          instr_valid_o;
    logic [31:0]   instr_o;
    logic [31:0]   pc_o;
    logic [TW-1:0] thread_id_o;

    fetch_stage #(.NUM_THREADS(NT), .RESET_PC(RPC), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_tid_i(redirect_tid_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
        .imem_valid_i(imem_valid_i), .imem_data_i(imem_data_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o), .thread_id_o(thread_id_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: per-thread PCs, a pending-tag queue and an output queue
    typedef struct { logic [31:0] pc; int tid; bit kill; } tag_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; int tid; bit kill; } ent_t;

    logic [31:0] m_pc [NT];
    int          m_rr;
    tag_t        m_pend [$];
    ent_t        m_buf  [$];
    logic [31:0] mem_q  [$];
    bit          model_ok  = 1'b0;
    bit          mem_en    = 1'b1;
    bit          mem_shown = 1'b0;
    bit          junk      = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int t);
        return 32'hA000_0000 | (32'(t) << 24) | {8'h00, a[23:0]};
    endfunction

    function automatic bit m_req();
        return !rst && ((m_pend.size() + m_buf.size()) < int'(DEP)) &&
               !(redirect_i && (int'(redirect_tid_i) == m_rr));
    endfunction

    // Model update on each rising edge, from inputs held stable over the cycle
    initial forever begin
        bit   acc, pop, resp;
        tag_t t;
        @(posedge clk);
        if (rst) begin
            foreach (m_pc[i]) m_pc[i] = RPC;
            m_rr = 0;
            m_pend.delete();
            m_buf.delete();
            mem_q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            acc  = m_req() && imem_ready_i;
            pop  = (m_buf.size() > 0) && (m_buf[0].kill || !stall_i);
            resp = imem_valid_i && (m_pend.size() > 0);
            if (redirect_i) begin
                foreach (m_pend[i]) if (m_pend[i].tid == int'(redirect_tid_i)) m_pend[i].kill = 1'b1;
                foreach (m_buf[i])  if (m_buf[i].tid == int'(redirect_tid_i))  m_buf[i].kill  = 1'b1;
            end
            if (pop) void'(m_buf.pop_front());
            if (resp) begin
                t = m_pend.pop_front();
                m_buf.push_back('{imem_data_i, t.pc, t.tid, t.kill});
            end
            if (mem_shown) void'(mem_q.pop_front());
            if (acc) begin
                m_pend.push_back('{m_pc[m_rr], m_rr, 1'b0});
                mem_q.push_back(mem_word(m_pc[m_rr], m_rr));
                m_pc[m_rr] = m_pc[m_rr] + 32'd4;
                m_rr = (m_rr + 1) % int'(NT);
            end
            if (redirect_i) m_pc[redirect_tid_i] = redirect_pc_i;
        end
    end

    // In-order memory with one-cycle latency; mem_en = 0 withholds responses
    initial forever begin
        @(posedge clk);
        #1;
        mem_shown    = mem_en && !junk && (mem_q.size() > 0);
        imem_valid_i = junk || mem_shown;
        imem_data_i  = mem_shown ? mem_q[0] : (junk ? 32'hBAD0_0000 : 32'h0);
    end

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin
        bit er, ev;
        @(negedge clk);
        if (model_ok) begin
            er = m_req();
            chk("imem_req_o", 32'(imem_req_o), 32'(er));
            if (er) chk("imem_addr_o", imem_addr_o, m_pc[m_rr]);
            ev = !rst && (m_buf.size() > 0) && !m_buf[0].kill;
            chk("instr_valid_o", 32'(instr_valid_o), 32'(ev));
            if (ev) begin
                chk("instr_o", instr_o, m_buf[0].data);
                chk("pc_o", pc_o, m_buf[0].pc);
                chk("thread_id_o", 32'(thread_id_o), 32'(m_buf[0].tid));
            end
            if (rst) begin
                chk("rst instr_o", instr_o, 32'h0);
                chk("rst pc_o", pc_o, 32'h0);
                chk("rst thread_id_o", 32'(thread_id_o), 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        stall_i = 1'b0; redirect_i = 1'b0; redirect_tid_i = '0; redirect_pc_i = '0;
        imem_ready_i = 1'b1; mem_en = 1'b1; junk = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_out(input int tid, input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            if (instr_valid_o && (int'(thread_id_o) == tid)) seen = 1'b1;
            else tick();
        end
    endtask

    initial begin
        logic [31:0] ea [6];
        logic [31:0] ep [5];
        logic [31:0] ei [5];
        int          et [5];
        bit          seen;
        rst = 1'b1; imem_valid_i = 1'b0; imem_data_i = '0;
        idle_inputs();

        // Free-running round robin after reset
        ea = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h4};
        et = '{0, 1, 2, 3, 0};
        ep = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4};
        ei = '{32'hA000_0000, 32'hA100_0000, 32'hA200_0000, 32'hA300_0000, 32'hA000_0004};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            #1;
            if (k < 6) begin
                chk("rr req", 32'(imem_req_o), 32'h1);
                chk("rr addr", imem_addr_o, ea[k]);
            end
            if (k < 2) chk("rr early valid", 32'(instr_valid_o), 32'h0);
            else begin
                chk("rr valid", 32'(instr_valid_o), 32'h1);
                chk("rr tid", 32'(thread_id_o), 32'(et[k-2]));
                chk("rr pc", pc_o, ep[k-2]);
                chk("rr instr", instr_o, ei[k-2]);
            end
            tick();
        end

        // Stall held: four requests fill the stage, then release drains in order
        stall_i = 1'b1;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("stall req", 32'(imem_req_o), (k < 4) ? 32'h1 : 32'h0);
            if (k >= 2) begin
                chk("stall frozen valid", 32'(instr_valid_o), 32'h1);
                chk("stall frozen tid", 32'(thread_id_o), 32'h0);
                chk("stall frozen instr", instr_o, 32'hA000_0000);
            end
            tick();
        end
        stall_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain tid", 32'(thread_id_o), 32'(k));
            chk("drain valid", 32'(instr_valid_o), 32'h1);
            if (k == 1) chk("drain refetch addr", imem_addr_o, 32'h4);
            tick();
        end

        // Redirect t1 while its entry sits in the full buffer
        stall_i = 1'b1;
        do_reset();
        for (int k = 0; k < 6; k++) tick();
        redirect_i = 1'b1; redirect_tid_i = 2'd1; redirect_pc_i = 32'h100;
        #1;
        chk("kill head unaffected", 32'(thread_id_o), 32'h0);
        tick();
        redirect_i = 1'b0; stall_i = 1'b0;
        #1;
        chk("kill t0 valid", 32'(instr_valid_o), 32'h1);
        tick();
        #1;
        chk("killed t1 hidden", 32'(instr_valid_o), 32'h0);
        chk("post-kill addr t0", imem_addr_o, 32'h4);
        tick();
        #1;
        chk("after kill tid", 32'(thread_id_o), 32'h2);
        chk("redirected t1 addr", imem_addr_o, 32'h100);
        wait_out(1, 10, seen);
        chk("t1 output seen", 32'(seen), 32'h1);
        if (seen) chk("redirected t1 pc", pc_o, 32'h100);

        // Redirect of the thread rr points at suppresses that cycle's request
        idle_inputs();
        do_reset();
        tick();
        tick();
        redirect_i = 1'b1; redirect_tid_i = 2'd2; redirect_pc_i = 32'h200;
        #1;
        chk("same-rr redirect req", 32'(imem_req_o), 32'h0);
        tick();
        redirect_i = 1'b0;
        #1;
        chk("same-rr next req", 32'(imem_req_o), 32'h1);
        chk("same-rr next addr", imem_addr_o, 32'h200);

        // PC wraps modulo 2^32
        do_reset();
        redirect_i = 1'b1; redirect_tid_i = 2'd0; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        #1;
        chk("wrap addr", imem_addr_o, 32'hFFFF_FFFC);
        for (int k = 0; k < 4; k++) tick();
        #1;
        chk("wrap next t0 req", 32'(imem_req_o), 32'h1);
        chk("wrap next t0 addr", imem_addr_o, 32'h0);

        // Reset with three requests outstanding and a stale response on the bus
        do_reset();
        mem_en = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1; junk = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("mid-rst req", 32'(imem_req_o), 32'h0);
            chk("mid-rst valid", 32'(instr_valid_o), 32'h0);
            chk("mid-rst pc_o", pc_o, 32'h0);
            tick();
        end
        rst = 1'b0; junk = 1'b0; mem_en = 1'b1;
        #1;
        chk("restart req", 32'(imem_req_o), 32'h1);
        chk("restart addr", imem_addr_o, RPC);
        chk("restart valid", 32'(instr_valid_o), 32'h0);
        wait_out(0, 8, seen);
        chk("restart t0 seen", 32'(seen), 32'h1);
        if (seen) chk("restart t0 pc", pc_o, RPC);

        // Mixed traffic checked by the model alone
        for (int k = 0; k < 300; k++) begin
            stall_i        = ($urandom_range(0, 3) == 0);
            imem_ready_i   = ($urandom_range(0, 3) != 0);
            mem_en         = ($urandom_range(0, 3) != 0);
            redirect_i     = ($urandom_range(0, 9) == 0);
            redirect_tid_i = 2'($urandom_range(0, 3));
            redirect_pc_i  = $urandom() & 32'hFFFF_FFFC;
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 20; k++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, time %0t", $time);
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end
endmodule
